cc_gen_unit: RTL

- Producer end of the condition-code path in the LC-3b pipeline.
- Generates nzp from CC-setting results, holds the architectural CC register, and forwards the youngest in-flight nzp to the branch comparator.
- Raises a stall when the youngest CC-setting instruction in MEM has no result yet (load pending on data memory).
- Sits between the MEM/WB pipeline registers and the branch-resolution logic in the MEM stage.

---
 rtl/cc_gen_unit.sv | 83 ++++++++
 1 files changed

// File: rtl/cc_gen_unit.sv
// cc_gen_unit: nzp generation, architectural CC register, youngest-producer
// forwarding to the branch comparator, and load-pending CC stall tracking.
module cc_gen_unit #(
  parameter int DATA_WIDTH = 16,
  parameter logic [2:0] RESET_CC = 3'b010,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  advance,
  input  logic                  flush,
  input  logic                  mem_valid,
  input  logic                  mem_load_cc,
  input  logic                  mem_result_ready,
  input  logic [DATA_WIDTH-1:0] mem_result,
  input  logic                  wb_valid,
  input  logic                  wb_load_cc,
  input  logic [DATA_WIDTH-1:0] wb_result,
  output logic [2:0]            cc_fwd,
  output logic [2:0]            cc_arch,
  output logic                  cc_stall,
  output logic [CNT_WIDTH-1:0]  stall_cycles
);
  typedef enum logic {READY, WAIT} state_t;

  state_t               r_state;
  logic [2:0]           r_cc_arch;
  logic [CNT_WIDTH-1:0] r_stall_cycles;
  logic                 w_mem_hit;
  logic                 w_wb_hit;
  logic                 w_cnt_sat;

  function automatic logic [2:0] gen(input logic [DATA_WIDTH-1:0] r);
    logic n, z;
    n = r[DATA_WIDTH-1];
    z = (r == '0);
    return {n, z, !n && !z};
  endfunction

  // mem_result/mem_result_ready are only looked at behind w_mem_hit so a
  // squashed or empty MEM slot cannot leak X into the outputs.
  assign w_mem_hit = mem_valid && mem_load_cc && !flush;
  assign w_wb_hit  = wb_valid && wb_load_cc;
  assign w_cnt_sat = &r_stall_cycles;

  always_comb begin
    cc_fwd   = (w_mem_hit && mem_result_ready) ? gen(mem_result) :
               w_wb_hit ? gen(wb_result) : r_cc_arch;
    cc_stall = w_mem_hit && !mem_result_ready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_cc_arch <= RESET_CC;
    else if (advance && w_wb_hit)
      r_cc_arch <= gen(wb_result);
  end

  // Each stalled cycle is counted as it happens, so an episode of N stalled
  // cycles adds exactly N.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= READY;
      r_stall_cycles <= '0;
    end else begin
      case (r_state)
        READY: if (cc_stall) begin
          r_state <= WAIT;
          if (!w_cnt_sat) r_stall_cycles <= r_stall_cycles + 1'b1;
        end
        WAIT: if (cc_stall) begin
          if (!w_cnt_sat) r_stall_cycles <= r_stall_cycles + 1'b1;
        end else begin
          r_state <= READY;
        end
        default: r_state <= READY;
      endcase
    end
  end

  assign cc_arch      = r_cc_arch;
  assign stall_cycles = r_stall_cycles;
endmodule
